div_unit: RTL and testbench

Iterative RV32M divider in the EXECUTE stage, producing DIV, DIVU, REM and REMU results. While a division runs it drives `div_stall`. The hazard unit uses that signal to freeze fetch, decode and execute, and the EX/MEM pipeline register uses it to insert bubbles. When the result is ready, the divider drops the stall for exactly one cycle so the held instruction can advance into MEM with its result.

---
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) with pipeline stall
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_e,
    input  logic [2:0]       funct3_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             flush_e,
    output logic             div_stall,
    output logic [WIDTH-1:0] div_result_e,
    output logic             result_valid_e
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, sel_rem_q, sel_rem_d;

    logic             is_signed, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs, spec_res, rem_it, quo_it, fin;
    logic [WIDTH:0]   rem_sh, diff;

    assign is_signed = ~funct3_e[0];
    assign a_neg     = is_signed & src_a_e[WIDTH-1];
    assign b_neg     = is_signed & src_b_e[WIDTH-1];
    assign a_abs     = a_neg ? -src_a_e : src_a_e;
    assign b_abs     = b_neg ? -src_b_e : src_b_e;
    assign div_zero  = src_b_e == '0;
    assign ovf       = is_signed & (src_a_e == {1'b1, {(WIDTH-1){1'b0}}}) & (&src_b_e);
    assign spec_res  = div_zero ? (funct3_e[1] ? src_a_e : '1)
                                : (funct3_e[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});

    // The partial remainder is shifted into a WIDTH+1 window so the trial subtract never overflows
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign rem_it = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_it = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign fin    = sel_rem_q ? (rneg_q ? -rem_it : rem_it) : (qneg_q ? -quo_it : quo_it);

    assign div_stall      = rst_n & ~flush_e & (((state_q == IDLE) & start_e) | (state_q == RUN));
    assign result_valid_e = rst_n & ~flush_e & (state_q == DONE);
    assign div_result_e   = result_valid_e ? res_q : '0;

    // Next-state and datapath update; flush wins over everything else
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        if (flush_e) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_e) begin
                    if (div_zero | ovf) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_abs;
                        dvs_d     = b_abs;
                        qneg_d    = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        sel_rem_d = funct3_e[1];
                        cnt_d     = '0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    rem_d = rem_it;
                    quo_d = quo_it;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        res_d   = fin;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering results, stall length, flush and reset
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start_e, flush_e;
    logic [2:0]  funct3_e;
    logic [31:0] src_a_e, src_b_e;
    logic        div_stall, result_valid_e;
    logic [31:0] div_result_e;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_e(start_e), .funct3_e(funct3_e),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .flush_e(flush_e),
        .div_stall(div_stall), .div_result_e(div_result_e), .result_valid_e(result_valid_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
        if (!f3[0]) return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return f3[1] ? a % b : a / b;
    endfunction

    // Scoreboard: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (result_valid_e) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else chk("result", div_result_e, sb.pop_front());
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall);
        int n;
        bit done;
        sb.push_back(model(f3, a, b));
        start_e = 1'b1; funct3_e = f3; src_a_e = a; src_b_e = b;
        n = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (div_stall) begin
                n++;
                @(posedge clk); #1;
                src_a_e = $urandom; src_b_e = $urandom;
            end else done = 1;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        chk("stall_len", 32'(n), 32'(exp_stall));
        chk("valid_done", {31'd0, result_valid_e}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input string tag);
        start_e = 1'b0;
        @(negedge clk);
        chk(tag, {30'd0, div_stall, result_valid_e}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic start_and_wait(input int cycles);
        sb.delete();
        start_e = 1'b1; funct3_e = 3'b101; src_a_e = 32'd1000; src_b_e = 32'd3;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst_n = 1'b0; start_e = 1'b0; flush_e = 1'b0; funct3_e = 3'b100; src_a_e = '0; src_b_e = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outs", {div_stall, result_valid_e, 30'd0} | div_result_e, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check("idle_after_reset");

        run_op(3'b101, 32'd100, 32'd7, 33);                 idle_check("no_restart_divu");
        run_op(3'b111, 32'd100, 32'd7, 33);                 idle_check("no_restart_remu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 33);           idle_check("idle_div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 33);           idle_check("idle_rem");
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 33);           idle_check("idle_rem2");
        run_op(3'b101, 32'd5, 32'd0, 1);                    idle_check("no_restart_dz");
        run_op(3'b110, 32'h8000_0001, 32'd0, 1);            idle_check("idle_rem_dz");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);    idle_check("idle_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);    idle_check("idle_ovf_rem");

        for (int i = 0; i < 8; i++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom | 32'd1;
            run_op(f3, a, b, 33);
        end
        idle_check("idle_random");

        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 33);
        run_op(3'b101, 32'd1, 32'hFFFF_FFFF, 33);
        idle_check("idle_b2b");

        // Reset arriving during iteration 10 must abandon the operation silently
        start_and_wait(11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", {div_stall, result_valid_e, 30'd0} | div_result_e, 32'd0);
        @(posedge clk); #1;
        start_e = 1'b0; rst_n = 1'b1;
        idle_check("rst_mid_idle");
        repeat (40) begin @(posedge clk); #1; end

        // Flush during iteration 20 drops the stall immediately and returns to IDLE
        start_and_wait(21);
        flush_e = 1'b1;
        @(negedge clk);
        chk("flush_outs", {30'd0, div_stall, result_valid_e}, 32'd0);
        @(posedge clk); #1;
        flush_e = 1'b0;
        idle_check("flush_idle");
        repeat (40) begin @(posedge clk); #1; end

        run_op(3'b101, 32'd100, 32'd7, 33);
        idle_check("after_flush");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
